spook_pre_processor: RTL and testbench

Input-side stage of the Spook-128su512v1 core. It parses the 32-bit public (pdi) and secret (sdi) streams: instruction words, segment headers and data words. It drives the key_* and bdi_* handshake, type and flag signals consumed directly by the Spook Controller. It strips all framing, zero-masks the unused bytes of partial final words, and tells the Controller about the message operation (decrypt) and whether a key update is requested (key_update).

---
 rtl/spook_pkg.sv | 51 +++++
 rtl/spook_pre_processor_if.sv | 61 ++++++
 rtl/spook_byte_mask.sv | 26 ++
 rtl/spook_pre_processor.sv | 270 +++++++++++++++++++++++++++
 tb/tb_spook_pre_processor.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spook_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spook_pkg
// Description : Shared constants for the Spook-128su512v1 input stage:
//               instruction opcodes, segment types, header field positions
//               and the pre-processor state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package spook_pkg;

    // Fixed stream geometry
    localparam int WORD_W       = 32;
    localparam int KEY_WORD_CNT = 4;
    localparam int SEG_LEN_W    = 16;

    // Instruction opcodes (word bits [31:28])
    localparam logic [3:0] OP_LDKEY  = 4'b0100;
    localparam logic [3:0] OP_ACTKEY = 4'b0111;
    localparam logic [3:0] OP_ENC    = 4'b0010;
    localparam logic [3:0] OP_DEC    = 4'b0011;

    // Segment types; AD_TYPE is also decoded by the Controller
    localparam logic [3:0] AD_TYPE   = 4'b0001;
    localparam logic [3:0] PT_TYPE   = 4'b0100;
    localparam logic [3:0] CT_TYPE   = 4'b0101;
    localparam logic [3:0] TAG_TYPE  = 4'b1000;
    localparam logic [3:0] KEY_TYPE  = 4'b1100;
    localparam logic [3:0] NPUB_TYPE = 4'b1101;

    // Segment header bit positions
    localparam int HDR_TYPE_MSB = 31;
    localparam int HDR_TYPE_LSB = 28;
    localparam int HDR_PARTIAL  = 27;
    localparam int HDR_LAST     = 26;
    localparam int HDR_EOI      = 25;
    localparam int HDR_EOT      = 24;
    localparam int HDR_LEN_MSB  = 15;
    localparam int HDR_LEN_LSB  = 0;

    // Pre-processor states
    typedef enum logic [2:0] {
        S_INST     = 3'd0,
        S_KEY_INST = 3'd1,
        S_KEY_HDR  = 3'd2,
        S_KEY_DATA = 3'd3,
        S_HDR      = 3'd4,
        S_DATA     = 3'd5
    } state_t;

endpackage : spook_pkg
`default_nettype wire

// File: rtl/spook_pre_processor_if.sv
`default_nettype none
// ============================================================================
// Module      : spook_pre_processor_if
// Description : Bundles the pdi/sdi input streams and the key/bdi output
//               streams of the Spook pre-processor. "slave" is the
//               pre-processor view, "master" the surrounding environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface spook_pre_processor_if;
    import spook_pkg::*;

    // Public data input
    logic [WORD_W-1:0] pdi_data;
    logic              pdi_valid;
    logic              pdi_ready;
    // Secret data input
    logic [WORD_W-1:0] sdi_data;
    logic              sdi_valid;
    logic              sdi_ready;
    // Key output to Controller
    logic [WORD_W-1:0] key;
    logic              key_valid;
    logic              key_ready;
    logic              key_update;
    // Block data output to Controller
    logic [WORD_W-1:0] bdi;
    logic              bdi_valid;
    logic              bdi_ready;
    logic [3:0]        bdi_type;
    logic              bdi_eot;
    logic              bdi_eoi;
    logic              bdi_partial;
    logic [2:0]        bdi_size;
    logic              decrypt;

    modport slave (
        input  pdi_data, pdi_valid,
        output pdi_ready,
        input  sdi_data, sdi_valid,
        output sdi_ready,
        output key, key_valid, key_update,
        input  key_ready,
        output bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi, bdi_partial, bdi_size,
        input  bdi_ready,
        output decrypt
    );

    modport master (
        output pdi_data, pdi_valid,
        input  pdi_ready,
        output sdi_data, sdi_valid,
        input  sdi_ready,
        input  key, key_valid, key_update,
        output key_ready,
        input  bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi, bdi_partial, bdi_size,
        output bdi_ready,
        input  decrypt
    );

endinterface : spook_pre_processor_if
`default_nettype wire

// File: rtl/spook_byte_mask.sv
`default_nettype none
// ============================================================================
// Module      : spook_byte_mask
// Description : Zeroes every byte of a word whose index is >= size.
//               Byte 0 is the most significant byte; size 3'b100 keeps all
//               four bytes and size 0 clears the whole word.
// Revision    : 1.0 - initial release
// ============================================================================
module spook_byte_mask #(
    parameter int W = 32
) (
    input  logic [W-1:0] data,
    input  logic [2:0]   size,
    output logic [W-1:0] masked
);

    // One comparator per byte lane; a lane survives only below the size
    generate
        for (genvar i = 0; i < W / 8; i++) begin : g_byte
            localparam logic [2:0] IDX = 3'(i);
            assign masked[W-1-8*i -: 8] = (IDX < size) ? data[W-1-8*i -: 8] : 8'h00;
        end
    endgenerate

endmodule : spook_byte_mask
`default_nettype wire

// File: rtl/spook_pre_processor.sv
`default_nettype none
// ============================================================================
// Module      : spook_pre_processor
// Description : Input stage of the Spook-128su512v1 core. Parses instruction
//               words, segment headers and data words on pdi/sdi, strips the
//               framing and forwards key and block data to the Controller
//               with per-word type, size and end-of-segment/input flags.
// Revision    : 1.0 - initial release
// ============================================================================
module spook_pre_processor
    import spook_pkg::*;
#(
    parameter int W         = WORD_W,
    parameter int KEY_WORDS = KEY_WORD_CNT,
    parameter int LEN_W     = SEG_LEN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    spook_pre_processor_if.slave   bus
);

    localparam int CNT_W = $clog2(KEY_WORDS + 1);

    // ------------------------------------------------------------------
    // State and latched context
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_next;

    logic              r_run;          // low during reset and the cycle after
    logic              r_decrypt;
    logic              r_key_update;
    logic [3:0]        r_type;
    logic              r_partial;
    logic              r_last;
    logic              r_eoi;
    logic              r_eot;
    logic [LEN_W-1:0]  r_remaining;
    logic [CNT_W-1:0]  r_key_cnt;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              w_pdi_ready;
    logic              w_sdi_ready;
    logic              w_bdi_valid;
    logic              w_key_valid;
    logic [W-1:0]      w_key;
    logic [2:0]        w_bdi_size;
    logic              w_bdi_eot;
    logic              w_bdi_eoi;
    logic [W-1:0]      w_bdi;

    logic              w_pdi_fire;
    logic              w_sdi_fire;
    logic [3:0]        w_pdi_op;
    logic [3:0]        w_sdi_op;
    logic [LEN_W-1:0]  w_hdr_len;
    logic              w_rem_ge4;
    logic              w_final;
    logic [2:0]        w_size_code;
    logic [LEN_W-1:0]  w_step;
    logic              w_key_last;

    assign w_pdi_fire  = bus.pdi_valid & w_pdi_ready;
    assign w_sdi_fire  = bus.sdi_valid & w_sdi_ready;
    assign w_pdi_op    = bus.pdi_data[HDR_TYPE_MSB:HDR_TYPE_LSB];
    assign w_sdi_op    = bus.sdi_data[HDR_TYPE_MSB:HDR_TYPE_LSB];
    assign w_hdr_len   = bus.pdi_data[LEN_W-1:0];

    // A data word carries min(remaining, 4) bytes; 3'b100 doubles as the value 4
    assign w_rem_ge4   = (r_remaining >= LEN_W'(4));
    assign w_final     = (r_remaining <= LEN_W'(4));
    assign w_size_code = w_rem_ge4 ? 3'b100 : r_remaining[2:0];
    assign w_step      = LEN_W'(w_size_code);
    assign w_key_last  = (r_key_cnt == CNT_W'(KEY_WORDS - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_INST;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_INST: begin
                if (w_pdi_fire) begin
                    if (w_pdi_op == OP_ACTKEY) begin
                        w_state_next = S_KEY_INST;
                    end else if (w_pdi_op == OP_ENC || w_pdi_op == OP_DEC) begin
                        w_state_next = S_HDR;
                    end
                end
            end
            S_KEY_INST: begin
                // Anything other than LDKEY is dropped while waiting
                if (w_sdi_fire && w_sdi_op == OP_LDKEY) begin
                    w_state_next = S_KEY_HDR;
                end
            end
            S_KEY_HDR: begin
                if (w_sdi_fire) begin
                    w_state_next = S_KEY_DATA;
                end
            end
            S_KEY_DATA: begin
                if (w_sdi_fire && w_key_last) begin
                    w_state_next = S_INST;
                end
            end
            S_HDR: begin
                if (w_pdi_fire) begin
                    if (w_hdr_len == '0) begin
                        // Empty segment: no data beats, only the last flag matters
                        w_state_next = bus.pdi_data[HDR_LAST] ? S_INST : S_HDR;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_pdi_fire && w_final) begin
                    w_state_next = r_last ? S_INST : S_HDR;
                end
            end
            default: w_state_next = S_INST;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake and data-path outputs per state
    // ------------------------------------------------------------------
    always_comb begin
        w_pdi_ready = 1'b0;
        w_sdi_ready = 1'b0;
        w_bdi_valid = 1'b0;
        w_key_valid = 1'b0;
        w_key       = '0;
        w_bdi_size  = 3'b000;
        w_bdi_eot   = 1'b0;
        w_bdi_eoi   = 1'b0;
        case (r_state)
            S_INST: begin
                w_pdi_ready = r_run;
            end
            S_KEY_INST, S_KEY_HDR: begin
                w_sdi_ready = 1'b1;
            end
            S_KEY_DATA: begin
                w_key       = bus.sdi_data;
                w_key_valid = bus.sdi_valid;
                w_sdi_ready = bus.key_ready;
            end
            S_HDR: begin
                w_pdi_ready = 1'b1;
            end
            S_DATA: begin
                w_bdi_valid = bus.pdi_valid;
                w_pdi_ready = bus.bdi_ready;
                w_bdi_size  = w_size_code;
                w_bdi_eot   = r_eot & w_final;
                w_bdi_eoi   = r_eoi & w_final;
            end
            default: begin
                w_pdi_ready = 1'b0;
            end
        endcase
    end

    // Outside S_DATA the size is zero, so the mask also clears bdi there
    spook_byte_mask #(
        .W      (W)
    ) u_byte_mask (
        .data   (bus.pdi_data),
        .size   (w_bdi_size),
        .masked (w_bdi)
    );

    // ------------------------------------------------------------------
    // Instruction, header and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run        <= 1'b0;
            r_decrypt    <= 1'b0;
            r_key_update <= 1'b0;
            r_type       <= 4'h0;
            r_partial    <= 1'b0;
            r_last       <= 1'b0;
            r_eoi        <= 1'b0;
            r_eot        <= 1'b0;
            r_remaining  <= '0;
            r_key_cnt    <= '0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                S_INST: begin
                    if (w_pdi_fire) begin
                        if (w_pdi_op == OP_ACTKEY) begin
                            r_key_update <= 1'b1;
                        end else if (w_pdi_op == OP_ENC) begin
                            r_decrypt <= 1'b0;
                        end else if (w_pdi_op == OP_DEC) begin
                            r_decrypt <= 1'b1;
                        end
                    end
                end
                S_KEY_HDR: begin
                    if (w_sdi_fire) begin
                        r_key_cnt <= '0;
                    end
                end
                S_KEY_DATA: begin
                    if (w_sdi_fire) begin
                        r_key_cnt <= r_key_cnt + CNT_W'(1);
                        if (w_key_last) begin
                            r_key_update <= 1'b0;
                        end
                    end
                end
                S_HDR: begin
                    if (w_pdi_fire) begin
                        r_type      <= bus.pdi_data[HDR_TYPE_MSB:HDR_TYPE_LSB];
                        r_partial   <= bus.pdi_data[HDR_PARTIAL];
                        r_last      <= bus.pdi_data[HDR_LAST];
                        r_eoi       <= bus.pdi_data[HDR_EOI];
                        r_eot       <= bus.pdi_data[HDR_EOT];
                        r_remaining <= w_hdr_len;
                    end
                end
                S_DATA: begin
                    if (w_pdi_fire) begin
                        r_remaining <= r_remaining - w_step;
                    end
                end
                default: begin
                    r_run <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------
    assign bus.pdi_ready   = w_pdi_ready;
    assign bus.sdi_ready   = w_sdi_ready;
    assign bus.key         = w_key;
    assign bus.key_valid   = w_key_valid;
    assign bus.key_update  = r_key_update;
    assign bus.bdi         = w_bdi;
    assign bus.bdi_valid   = w_bdi_valid;
    assign bus.bdi_type    = r_type;
    assign bus.bdi_eot     = w_bdi_eot;
    assign bus.bdi_eoi     = w_bdi_eoi;
    assign bus.bdi_partial = r_partial;
    assign bus.bdi_size    = w_bdi_size;
    assign bus.decrypt     = r_decrypt;

endmodule : spook_pre_processor
`default_nettype wire

// File: tb/tb_spook_pre_processor.sv
`default_nettype none
// ============================================================================
// Module      : tb_spook_pre_processor
// Description : Directed self-checking bench for spook_pre_processor:
//               key load, encrypt/decrypt framing, backpressure, mid-segment
//               reset and zero-length / unknown words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spook_pre_processor;
    import spook_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  typ;
        logic [2:0]  size;
        logic        eot;
        logic        eoi;
    } beat_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    beat_t       bdi_q[$];
    logic [31:0] key_q[$];
    logic        kupd_q[$];

    spook_pre_processor_if bus_if ();

    spook_pre_processor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted beat half a cycle before its transfer edge
    always @(negedge clk) begin
        if (rst && bus_if.bdi_valid && bus_if.bdi_ready)
            bdi_q.push_back({bus_if.bdi, bus_if.bdi_type, bus_if.bdi_size, bus_if.bdi_eot, bus_if.bdi_eoi});
        if (rst && bus_if.key_valid && bus_if.key_ready) begin
            key_q.push_back(bus_if.key);
            kupd_q.push_back(bus_if.key_update);
        end
    end

    function automatic logic [15:0] outs();
        return {bus_if.pdi_ready, bus_if.sdi_ready, bus_if.bdi_valid, bus_if.key_valid,
                bus_if.key_update, bus_if.decrypt, bus_if.bdi_eot, bus_if.bdi_eoi,
                bus_if.bdi_partial, bus_if.bdi_type, bus_if.bdi_size};
    endfunction

    task automatic send_pdi(input logic [31:0] w);
        int n = 0;
        bus_if.pdi_data  = w;
        bus_if.pdi_valid = 1'b1;
        #1;
        while (!bus_if.pdi_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!bus_if.pdi_ready) begin
            checks++; failures++;
            $display("FAIL pdi_timeout word=%h pdi_ready=%b required=1", w, bus_if.pdi_ready);
        end else begin
            @(posedge clk); #1;
        end
        bus_if.pdi_valid = 1'b0;
        bus_if.pdi_data  = '0;
    endtask

    task automatic send_sdi(input logic [31:0] w);
        int n = 0;
        bus_if.sdi_data  = w;
        bus_if.sdi_valid = 1'b1;
        #1;
        while (!bus_if.sdi_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!bus_if.sdi_ready) begin
            checks++; failures++;
            $display("FAIL sdi_timeout word=%h sdi_ready=%b required=1", w, bus_if.sdi_ready);
        end else begin
            @(posedge clk); #1;
        end
        bus_if.sdi_valid = 1'b0;
        bus_if.sdi_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus_if.pdi_data  = 32'h2000_0000;
        bus_if.pdi_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs() !== 16'h0) begin
            failures++; $display("FAIL reset_outputs got=%h required=0000", outs());
        end
        checks++;
        if ({bus_if.bdi, bus_if.key} !== 64'h0) begin
            failures++; $display("FAIL reset_data got=%h required=0", {bus_if.bdi, bus_if.key});
        end
        checks++;
        if (dut.r_remaining !== 16'h0) begin
            failures++; $display("FAIL reset_remaining got=%h required=0000", dut.r_remaining);
        end
        bus_if.pdi_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus_if.pdi_ready, bus_if.sdi_ready} !== 2'b10) begin
            failures++; $display("FAIL idle_ready got=%b required=10", {bus_if.pdi_ready, bus_if.sdi_ready});
        end
    endtask

    task automatic test_key_load();
        logic [31:0] kw [4];
        kw[0] = 32'h0123_4567; kw[1] = 32'h89AB_CDEF; kw[2] = 32'hDEAD_BEEF; kw[3] = 32'h5A5A_A5A5;
        key_q.delete(); kupd_q.delete();
        bus_if.sdi_data = 32'h4000_0000; bus_if.sdi_valid = 1'b1;
        #1;
        checks++;
        if (bus_if.sdi_ready !== 1'b0) begin
            failures++; $display("FAIL sdi_ready_in_inst got=%b required=0", bus_if.sdi_ready);
        end
        bus_if.sdi_valid = 1'b0;
        send_pdi(32'h7000_0000);
        checks++;
        if (bus_if.key_update !== 1'b1) begin
            failures++; $display("FAIL key_update_after_actkey got=%b required=1", bus_if.key_update);
        end
        send_sdi(32'h4000_0000);
        send_sdi(32'hC000_0010);
        for (int i = 0; i < 4; i++) send_sdi(kw[i]);
        checks++;
        if (key_q.size() !== 4) begin
            failures++; $display("FAIL key_count got=%0d required=4", key_q.size());
        end
        for (int i = 0; i < 4 && i < key_q.size(); i++) begin
            checks++;
            if ({key_q[i], kupd_q[i]} !== {kw[i], 1'b1}) begin
                failures++; $display("FAIL key_word%0d got=%h/%b required=%h/1", i, key_q[i], kupd_q[i], kw[i]);
            end
        end
        checks++;
        if ({bus_if.key_update, dut.r_state} !== {1'b0, S_INST}) begin
            failures++; $display("FAIL key_done got=%b/%0d required=0/%0d", bus_if.key_update, dut.r_state, S_INST);
        end
    endtask

    task automatic test_encrypt();
        beat_t exp [6];
        exp[0] = {32'h1111_1111, NPUB_TYPE, 3'b100, 1'b0, 1'b0};
        exp[1] = {32'h2222_2222, NPUB_TYPE, 3'b100, 1'b0, 1'b0};
        exp[2] = {32'h3333_3333, NPUB_TYPE, 3'b100, 1'b0, 1'b0};
        exp[3] = {32'h4444_4444, NPUB_TYPE, 3'b100, 1'b1, 1'b0};
        exp[4] = {32'hAABB_CCDD, AD_TYPE,   3'b100, 1'b0, 1'b0};
        exp[5] = {32'hEE00_0000, AD_TYPE,   3'b001, 1'b1, 1'b1};
        bdi_q.delete();
        send_pdi(32'h2000_0000);
        checks++;
        if (bus_if.decrypt !== 1'b0) begin
            failures++; $display("FAIL enc_decrypt got=%b required=0", bus_if.decrypt);
        end
        send_pdi(32'hD100_0010);
        send_pdi(32'h1111_1111); send_pdi(32'h2222_2222);
        send_pdi(32'h3333_3333); send_pdi(32'h4444_4444);
        send_pdi(32'h1300_0005);
        send_pdi(32'hAABB_CCDD); send_pdi(32'hEE12_3456);
        send_pdi(32'h4700_0000);
        checks++;
        if (bdi_q.size() !== 6) begin
            failures++; $display("FAIL enc_beat_count got=%0d required=6", bdi_q.size());
        end
        for (int i = 0; i < 6 && i < bdi_q.size(); i++) begin
            checks++;
            if (bdi_q[i] !== exp[i]) begin
                failures++; $display("FAIL enc_beat%0d got=%h required=%h", i, bdi_q[i], exp[i]);
            end
        end
        checks++;
        if (dut.r_state !== S_INST) begin
            failures++; $display("FAIL enc_end_state got=%0d required=%0d", dut.r_state, S_INST);
        end
    endtask

    task automatic test_decrypt_tag();
        beat_t exp [10];
        for (int i = 0; i < 4; i++) exp[i] = {32'h1010_1010 * (i + 1), NPUB_TYPE, 3'b100, i == 3, 1'b0};
        exp[4] = {32'hCAFE_BABE, CT_TYPE, 3'b100, 1'b0, 1'b0};
        exp[5] = {32'h0102_0304, CT_TYPE, 3'b100, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) exp[6+i] = {32'h7A60_0000 + i, TAG_TYPE, 3'b100, i == 3, 1'b0};
        bdi_q.delete();
        send_pdi(32'h3000_0000);
        checks++;
        if (bus_if.decrypt !== 1'b1) begin
            failures++; $display("FAIL dec_decrypt got=%b required=1", bus_if.decrypt);
        end
        send_pdi(32'hD100_0010);
        for (int i = 0; i < 4; i++) send_pdi(32'h1010_1010 * (i + 1));
        send_pdi(32'h5300_0008);
        send_pdi(32'hCAFE_BABE); send_pdi(32'h0102_0304);
        send_pdi(32'h8500_0010);
        for (int i = 0; i < 3; i++) send_pdi(32'h7A60_0000 + i);
        checks++;
        if (dut.r_state !== S_DATA) begin
            failures++; $display("FAIL dec_tag_pending got=%0d required=%0d", dut.r_state, S_DATA);
        end
        send_pdi(32'h7A60_0003);
        checks++;
        if (bdi_q.size() !== 10) begin
            failures++; $display("FAIL dec_beat_count got=%0d required=10", bdi_q.size());
        end
        for (int i = 0; i < 10 && i < bdi_q.size(); i++) begin
            checks++;
            if (bdi_q[i] !== exp[i]) begin
                failures++; $display("FAIL dec_beat%0d got=%h required=%h", i, bdi_q[i], exp[i]);
            end
        end
        checks++;
        if (dut.r_state !== S_INST) begin
            failures++; $display("FAIL dec_end_state got=%0d required=%0d", dut.r_state, S_INST);
        end
    endtask

    task automatic test_backpressure();
        bdi_q.delete();
        send_pdi(32'h2000_0000);
        send_pdi(32'h1300_0005);
        bus_if.pdi_data  = 32'hAABB_CCDD;
        bus_if.pdi_valid = 1'b1;
        bus_if.bdi_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ({bus_if.pdi_ready, bus_if.bdi_valid, bus_if.bdi, bus_if.bdi_type, bus_if.bdi_size,
                 bus_if.bdi_eot, bus_if.bdi_eoi, dut.r_remaining}
                !== {1'b0, 1'b1, 32'hAABB_CCDD, AD_TYPE, 3'b100, 1'b0, 1'b0, 16'd5}) begin
                failures++;
                $display("FAIL bp_hold%0d got rdy=%b vld=%b bdi=%h type=%h size=%b eot=%b eoi=%b rem=%0d required 0 1 aabbccdd 1 100 0 0 5",
                         c, bus_if.pdi_ready, bus_if.bdi_valid, bus_if.bdi, bus_if.bdi_type,
                         bus_if.bdi_size, bus_if.bdi_eot, bus_if.bdi_eoi, dut.r_remaining);
            end
            @(posedge clk); #1;
        end
        bus_if.bdi_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.pdi_valid = 1'b0;
        send_pdi(32'hEE12_3456);
        send_pdi(32'h4700_0000);
        checks++;
        if (bdi_q.size() !== 2 || bdi_q[0] !== {32'hAABB_CCDD, AD_TYPE, 3'b100, 1'b0, 1'b0}
            || bdi_q[1] !== {32'hEE00_0000, AD_TYPE, 3'b001, 1'b1, 1'b1}) begin
            failures++; $display("FAIL bp_beats got=%0d beats required=2 (aabbccdd, ee000000)", bdi_q.size());
        end
    endtask

    task automatic test_reset_mid();
        send_pdi(32'h3000_0000);
        send_pdi(32'hD100_0010);
        send_pdi(32'h1111_1111); send_pdi(32'h2222_2222);
        bus_if.pdi_data  = 32'h3333_3333;
        bus_if.pdi_valid = 1'b1;
        #1;
        checks++;
        if ({bus_if.bdi_valid, bus_if.decrypt} !== 2'b11) begin
            failures++; $display("FAIL mid_pre_reset got=%b required=11", {bus_if.bdi_valid, bus_if.decrypt});
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (outs() !== 16'h0 || bus_if.bdi !== 32'h0) begin
            failures++; $display("FAIL mid_reset_outputs got=%h bdi=%h required=0000 0", outs(), bus_if.bdi);
        end
        checks++;
        if ({dut.r_state, dut.r_remaining} !== {S_INST, 16'd0}) begin
            failures++; $display("FAIL mid_reset_state got=%0d/%0d required=%0d/0", dut.r_state, dut.r_remaining, S_INST);
        end
        bus_if.pdi_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        bdi_q.delete();
        send_pdi(32'h2000_0000);
        send_pdi(32'h1300_0005);
        send_pdi(32'hAABB_CCDD); send_pdi(32'hEE12_3456);
        send_pdi(32'h4700_0000);
        checks++;
        if (bdi_q.size() !== 2 || bdi_q[0] !== {32'hAABB_CCDD, AD_TYPE, 3'b100, 1'b0, 1'b0}
            || bdi_q[1] !== {32'hEE00_0000, AD_TYPE, 3'b001, 1'b1, 1'b1}) begin
            failures++; $display("FAIL mid_fresh_beats got=%0d beats required=2 (aabbccdd, ee000000)", bdi_q.size());
        end
        checks++;
        if ({bus_if.decrypt, dut.r_state} !== {1'b0, S_INST}) begin
            failures++; $display("FAIL mid_fresh_end got=%b/%0d required=0/%0d", bus_if.decrypt, dut.r_state, S_INST);
        end
    endtask

    task automatic test_zero_len();
        bdi_q.delete();
        send_pdi(32'hF000_0000);
        checks++;
        if ({dut.r_state, bus_if.decrypt, bus_if.key_update} !== {S_INST, 1'b0, 1'b0}) begin
            failures++; $display("FAIL unknown_op got=%0d/%b/%b required=%0d/0/0", dut.r_state, bus_if.decrypt, bus_if.key_update, S_INST);
        end
        send_pdi(32'h2000_0000);
        send_pdi(32'h1000_0000);
        checks++;
        if ({dut.r_state, bus_if.pdi_ready, bdi_q.size()} !== {S_HDR, 1'b1, 32'd0}) begin
            failures++; $display("FAIL zero_len_wait got=%0d/%b/%0d required=%0d/1/0", dut.r_state, bus_if.pdi_ready, bdi_q.size(), S_HDR);
        end
        send_pdi(32'h1300_0002);
        send_pdi(32'h1234_5678);
        send_pdi(32'h4700_0000);
        checks++;
        if (bdi_q.size() !== 1 || bdi_q[0] !== {32'h1234_0000, AD_TYPE, 3'b010, 1'b1, 1'b1}) begin
            failures++; $display("FAIL zero_len_follow got=%0d beats first=%h required=1 beat %h",
                                 bdi_q.size(), (bdi_q.size() > 0) ? bdi_q[0] : beat_t'(0),
                                 {32'h1234_0000, AD_TYPE, 3'b010, 1'b1, 1'b1});
        end
        checks++;
        if (dut.r_state !== S_INST) begin
            failures++; $display("FAIL zero_len_end got=%0d required=%0d", dut.r_state, S_INST);
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b0;
        bus_if.pdi_data  = '0;
        bus_if.pdi_valid = 1'b0;
        bus_if.sdi_data  = '0;
        bus_if.sdi_valid = 1'b0;
        bus_if.key_ready = 1'b1;
        bus_if.bdi_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_key_load();
        test_encrypt();
        test_decrypt_tag();
        test_backpressure();
        test_reset_mid();
        test_zero_len();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_spook_pre_processor
`default_nettype wire
